// File: rtl/ths8200_video_out_pkg.sv
// Shared constants, state encoding and byte-lane helpers for the THS8200 video output path.
// Timing defaults describe 1280x720 progressive raster.
package ths8200_video_out_pkg;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_TOTAL  = 1650;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_TOTAL  = 750;
    localparam bit DEF_SYNC_POL = 1'b1;

    localparam logic [15:0] BLACK_PIXEL = 16'h1080;

    // Packed 4:2:2 word layout: {Y0, Cb, Y1, Cr}
    localparam int Y0_LSB = 24;
    localparam int CB_LSB = 16;
    localparam int Y1_LSB = 8;
    localparam int CR_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    function automatic logic [15:0] pick_pixel(input logic [31:0] word, input logic odd);
        if (odd)
            return {word[Y1_LSB +: 8], word[CR_LSB +: 8]};
        return {word[Y0_LSB +: 8], word[CB_LSB +: 8]};
    endfunction

endpackage

// File: rtl/ths8200_video_out_if.sv
// DCFIFO read port plus THS8200 pixel/sync bus. The video output block is the master side.
interface ths8200_video_out_if;

    logic        da_init_done;
    logic        dcfifo_empty;
    logic        dcfifo_rdreq;
    logic [31:0] dcfifo_q;
    logic [15:0] dac_data;
    logic        dac_hsync;
    logic        dac_vsync;
    logic        dac_blank_n;
    logic        underflow;

    modport master (
        input  da_init_done, dcfifo_empty, dcfifo_q,
        output dcfifo_rdreq, dac_data, dac_hsync, dac_vsync, dac_blank_n, underflow
    );

    modport slave (
        output da_init_done, dcfifo_empty, dcfifo_q,
        input  dcfifo_rdreq, dac_data, dac_hsync, dac_vsync, dac_blank_n, underflow
    );

endinterface

// File: rtl/ths8200_video_out_timing_gen.sv
// Raster counters, active/sync decode and a 2-stage delay aligning sync/blank with pixel data.
// Counters sit at 0 whenever the generator is not running.
module video_timing_gen
    import ths8200_video_out_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic flush_i,
    output logic active_o,
    output logic even_o,
    output logic active_s1_o,
    output logic odd_s1_o,
    output logic hsync_o,
    output logic vsync_o,
    output logic blank_n_o
);

    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt_q;
    logic [VW-1:0] v_cnt_q;
    logic          hsync_d, vsync_d;
    logic          active_s1_q, odd_s1_q, hsync_s1_q, vsync_s1_q;
    logic          active_s2_q, hsync_s2_q, vsync_s2_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i || !run_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_q <= '0;
            v_cnt_q <= (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end else begin
            h_cnt_q <= h_cnt_q + HW'(1);
        end
    end

    // Decode is gated by run_i so the held-at-zero counters never look active.
    assign active_o = run_i && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign even_o   = ~h_cnt_q[0];
    assign hsync_d  = run_i && (h_cnt_q >= H_HS_BEG) && (h_cnt_q < H_HS_END);
    assign vsync_d  = run_i && (v_cnt_q >= V_VS_BEG) && (v_cnt_q < V_VS_END);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            active_s1_q <= 1'b0;
            odd_s1_q    <= 1'b0;
            hsync_s1_q  <= 1'b0;
            vsync_s1_q  <= 1'b0;
            active_s2_q <= 1'b0;
            hsync_s2_q  <= 1'b0;
            vsync_s2_q  <= 1'b0;
        end else begin
            active_s1_q <= active_o;
            odd_s1_q    <= h_cnt_q[0];
            hsync_s1_q  <= hsync_d;
            vsync_s1_q  <= vsync_d;
            active_s2_q <= active_s1_q;
            hsync_s2_q  <= hsync_s1_q;
            vsync_s2_q  <= vsync_s1_q;
        end
    end

    assign active_s1_o = active_s1_q;
    assign odd_s1_o    = odd_s1_q;
    assign hsync_o     = hsync_s2_q ? SYNC_POL : ~SYNC_POL;
    assign vsync_o     = vsync_s2_q ? SYNC_POL : ~SYNC_POL;
    assign blank_n_o   = active_s2_q;

endmodule

// File: rtl/ths8200_video_out.sv
// DCFIFO read side feeding the THS8200: start-up FSM, word fetch, 4:2:2 pixel mux, underflow flag.
// Starved word slots turn into two black pixels; raster timing never stalls.
module ths8200_video_out
    import ths8200_video_out_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input logic                    clk,
    input logic                    rst,
    ths8200_video_out_if.master    bus
);

    state_e      state_q;
    logic        init_sync_q;
    logic        run, flush, active, even, active_s1, odd_s1, slot, rdreq;
    logic        rd_d1_q, valid_q, underflow_q;
    logic [31:0] word_q;
    logic [15:0] dac_data_q, dac_data_d;

    always_ff @(posedge clk) begin
        if (rst)
            init_sync_q <= 1'b0;
        else
            init_sync_q <= bus.da_init_done;
    end

    always_ff @(posedge clk) begin
        if (rst || !init_sync_q) begin
            state_q <= ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:      state_q <= ST_WAIT_DATA;
                ST_WAIT_DATA: if (!bus.dcfifo_empty) state_q <= ST_RUN;
                ST_RUN:       state_q <= ST_RUN;
                default:      state_q <= ST_IDLE;
            endcase
        end
    end

    assign run   = (state_q == ST_RUN);
    assign flush = !init_sync_q;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_TOTAL (H_TOTAL),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_TOTAL (V_TOTAL),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .run_i       (run),
        .flush_i     (flush),
        .active_o    (active),
        .even_o      (even),
        .active_s1_o (active_s1),
        .odd_s1_o    (odd_s1),
        .hsync_o     (bus.dac_hsync),
        .vsync_o     (bus.dac_vsync),
        .blank_n_o   (bus.dac_blank_n)
    );

    // A word slot is every even active pixel; gating by the synced init stops reads the cycle it drops.
    assign slot  = init_sync_q && active && even;
    assign rdreq = slot && !bus.dcfifo_empty;

    always_comb begin
        dac_data_d = BLACK_PIXEL;
        if (active_s1) begin
            if (!odd_s1)
                dac_data_d = rd_d1_q ? pick_pixel(bus.dcfifo_q, 1'b0) : BLACK_PIXEL;
            else
                dac_data_d = valid_q ? pick_pixel(word_q, 1'b1) : BLACK_PIXEL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_d1_q    <= 1'b0;
            valid_q    <= 1'b0;
            word_q     <= '0;
            dac_data_q <= BLACK_PIXEL;
        end else begin
            rd_d1_q <= rdreq;
            if (!odd_s1) begin
                valid_q <= rd_d1_q;
                if (rd_d1_q)
                    word_q <= bus.dcfifo_q;
            end
            dac_data_q <= dac_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            underflow_q <= 1'b0;
        else if (slot && bus.dcfifo_empty)
            underflow_q <= 1'b1;
    end

    assign bus.dcfifo_rdreq = rdreq;
    assign bus.dac_data     = dac_data_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_ths8200_video_out.sv
// Bench for ths8200_video_out on a reduced 16/2/2/24 x 4/1/1/8 raster with a FIFO model,
// a pixel scoreboard and a table of hand-derived sync/blank positions.
module tb_ths8200_video_out;

    localparam int HA = 16, HF = 2, HS = 2, HT = 24;
    localparam int VA = 4,  VF = 1, VS = 1, VT = 8;

    typedef struct {
        int   t;
        logic hs;
        logic vs;
        logic bl;
    } sync_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ths8200_video_out_if bus();

    logic        force_empty = 1'b0;
    logic        fifo_empty_flag = 1'b1;
    logic [31:0] fifo_words[$];
    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cur_t = -1;
    int          starve_t = -100;
    int          rd_line_cnt = 0;
    int          starve_line_cnt = 0;
    logic        exp_uf = 1'b0;
    sync_vec_t   vecs[17];

    assign bus.dcfifo_empty = force_empty | fifo_empty_flag;

    // Normal-mode FIFO: data appears the cycle after rdreq.
    always @(posedge clk) begin
        if (bus.dcfifo_rdreq && fifo_words.size() != 0)
            bus.dcfifo_q <= fifo_words.pop_front();
        fifo_empty_flag <= (fifo_words.size() == 0);
    end

    ths8200_video_out #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_TOTAL (HT),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_TOTAL (VT),
        .SYNC_POL (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic bit pos_active(int p);
        if (p < 0)
            return 1'b0;
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %h, expected %h", name, cur_t, act, exp);
        end
    endtask

    task automatic check_idle_outputs(logic uf);
        check("rdreq_idle", 32'(bus.dcfifo_rdreq), 32'd0);
        check("data_idle", 32'(bus.dac_data), 32'h1080);
        check("hsync_idle", 32'(bus.dac_hsync), 32'd0);
        check("vsync_idle", 32'(bus.dac_vsync), 32'd0);
        check("blank_n_idle", 32'(bus.dac_blank_n), 32'd0);
        check("underflow_idle", 32'(bus.underflow), 32'(uf));
    endtask

    task automatic mon_cycle();
        int          p;
        int          h;
        int          v;
        bit          slot;
        bit          exp_rd;
        logic [31:0] w;
        p = cur_t - 2;
        h = cur_t % HT;
        v = (cur_t / HT) % VT;
        if (pos_active(p)) begin
            check("blank_n_active", 32'(bus.dac_blank_n), 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard at t=%0d: got pixel %h, expected none queued", cur_t, bus.dac_data);
            end else begin
                check("dac_data", 32'(bus.dac_data), 32'(exp_q.pop_front()));
            end
        end else begin
            check("blank_n_blank", 32'(bus.dac_blank_n), 32'd0);
            check("data_blank", 32'(bus.dac_data), 32'h1080);
        end
        check("underflow", 32'(bus.underflow), 32'(exp_uf));
        slot   = pos_active(cur_t) && (h % 2 == 0);
        exp_rd = slot && !bus.dcfifo_empty;
        check("rdreq", 32'(bus.dcfifo_rdreq), 32'(exp_rd));
        if (bus.dcfifo_rdreq)
            rd_line_cnt++;
        if (slot) begin
            if (exp_rd) begin
                w = fifo_words[0];
                exp_q.push_back(w[31:16]);
                exp_q.push_back(w[15:0]);
            end else begin
                exp_q.push_back(16'h1080);
                exp_q.push_back(16'h1080);
                exp_uf = 1'b1;
                starve_line_cnt++;
            end
        end
        if (h == HT - 1) begin
            check("reads_per_line", 32'(rd_line_cnt), (v < VA) ? 32'(HA / 2 - starve_line_cnt) : 32'd0);
            $display("line v=%0d reads=%0d starved=%0d", v, rd_line_cnt, starve_line_cnt);
            rd_line_cnt     = 0;
            starve_line_cnt = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cur_t++;
        force_empty = (cur_t == starve_t);
        #1;
        mon_cycle();
    endtask

    // Sync flop, IDLE->WAIT_DATA, WAIT_DATA->RUN: the third edge starts line 0 pixel 0.
    task automatic raise_init();
        bus.da_init_done = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("rdreq_startup", 32'(bus.dcfifo_rdreq), 32'd0);
        end
        cur_t           = -1;
        rd_line_cnt     = 0;
        starve_line_cnt = 0;
    endtask

    initial begin
        vecs[0]  = '{2,   1'b0, 1'b0, 1'b1};
        vecs[1]  = '{17,  1'b0, 1'b0, 1'b1};
        vecs[2]  = '{18,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{19,  1'b0, 1'b0, 1'b0};
        vecs[4]  = '{20,  1'b1, 1'b0, 1'b0};
        vecs[5]  = '{21,  1'b1, 1'b0, 1'b0};
        vecs[6]  = '{22,  1'b0, 1'b0, 1'b0};
        vecs[7]  = '{89,  1'b0, 1'b0, 1'b1};
        vecs[8]  = '{98,  1'b0, 1'b0, 1'b0};
        vecs[9]  = '{122, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{140, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{145, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{146, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{188, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{193, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{194, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{218, 1'b0, 1'b0, 1'b1};

        bus.da_init_done = 1'b0;
        for (int i = 0; i < 8; i++)
            fifo_words.push_back(32'hA22CA28E);
        for (int i = 0; i < 72; i++)
            fifo_words.push_back($urandom);

        // Power-up: reset, then 100 cycles with init low and a non-empty FIFO.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            check_idle_outputs(1'b0);
        end

        // Streaming over two frames with one starved slot at line 1, pixel 6.
        starve_t = 30;
        raise_init();
        for (int i = 0; i < 17; i++) begin
            while (cur_t < vecs[i].t)
                step();
            check("hsync_pos", 32'(bus.dac_hsync), 32'(vecs[i].hs));
            check("vsync_pos", 32'(bus.dac_vsync), 32'(vecs[i].vs));
            check("blank_n_pos", 32'(bus.dac_blank_n), 32'(vecs[i].bl));
        end
        while (cur_t < 387)
            step();

        // Init drops just before an even active slot.
        bus.da_init_done = 1'b0;
        @(negedge clk);
        #1;
        check("rdreq_after_drop", 32'(bus.dcfifo_rdreq), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check_idle_outputs(1'b1);
        end

        // Restart: raster resumes at h=0, v=0; underflow still held.
        exp_q.delete();
        for (int i = 0; i < 40; i++)
            fifo_words.push_back($urandom);
        starve_t = -100;
        raise_init();
        while (cur_t < 197)
            step();

        // Synchronous reset mid active line.
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs(1'b0);
        @(negedge clk);
        #1;
        check_idle_outputs(1'b0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
